// File: rtl/store_merge_unit.sv
// store_merge_unit: SW/SH/SB narrowing into a word-only memory, with
// read-modify-write for sub-word lanes and misalignment rejection.
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              misalign_err
);
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0] data_q;
    logic [31:0] wdata_q, mask, lane;
    logic half_q, err_q, accept, bad;
    assign req_ready = state == IDLE && !err_q;
    assign accept = req_valid && req_ready;
    assign bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign mask = half_q ? 32'hFFFF << {addr_q[1], 4'b0} : 32'hFF << {addr_q[1:0], 3'b0};
    assign lane = half_q ? {2{data_q}} : {4{data_q[7:0]}};
    assign mem_rd_en = state == READ;
    assign mem_wr_en = state == WRITE;
    assign done = state == WRITE;
    assign misalign_err = err_q;
    assign mem_addr = state == IDLE ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = state == WRITE ? wdata_q : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept && !bad ? (req_size == 2'b10 ? WRITE : READ) : IDLE;
            READ:  state_nx = WAIT;
            WAIT:  state_nx = WRITE;
            WRITE: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            half_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nx;
            err_q <= accept && bad;
            if (accept) begin
                addr_q  <= req_addr;
                data_q  <= req_data[15:0];
                half_q  <= req_size[0];
                wdata_q <= req_data;
            end
            // rdata arrives the cycle after the read strobe; merge the new lane into it
            if (state == WAIT)
                wdata_q <= (mem_rdata & ~mask) | (lane & mask);
        end
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed + random stores against a byte-array reference memory.
module tb_store_merge_unit;
    logic clk = 0, reset = 1, req_valid = 0, req_ready;
    logic [31:0] req_addr = 0, req_data = 0, mem_addr, mem_rdata = 0, mem_wdata;
    logic [1:0] req_size = 0;
    logic mem_rd_en, mem_wr_en, done, misalign_err;
    logic [31:0] mem [0:15] = '{default: 32'h0};
    logic [7:0] refmem [0:63] = '{default: 8'h0};
    int checks = 0, errors = 0;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .done(done),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[5:2]];
        if (mem_wr_en) mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {refmem[4*w+3], refmem[4*w+2], refmem[4*w+1], refmem[4*w]};
    endfunction

    function automatic logic is_bad(input logic [31:0] a, input logic [1:0] s);
        return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
        for (int i = 0; i < n; i++) refmem[int'(a[5:0]) + i] = d[8*i +: 8];
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        logic err;
        logic [31:0] w;
        err = is_bad(a, s);
        if (!err) ref_store(a, d, s);
        w = ref_word(int'(a[5:2]));
        chk("ready_before", req_ready, 1);
        req_valid = 1; req_addr = a; req_data = d; req_size = s;
        step();
        req_valid = 0; req_addr = $urandom; req_data = $urandom; req_size = 2'($urandom);
        if (err) begin
            chk("err_pulse", misalign_err, 1);
            chk("err_rd", mem_rd_en, 0);
            chk("err_wr", mem_wr_en, 0);
            chk("err_ready", req_ready, 0);
            step();
            chk("err_off", misalign_err, 0);
            chk("err_wr2", mem_wr_en | mem_rd_en, 0);
        end else if (s == 2'd2) begin
            chk("sw_wr", mem_wr_en, 1);
            chk("sw_done", done, 1);
            chk("sw_rd", mem_rd_en, 0);
            chk("sw_addr", mem_addr, {a[31:2], 2'b00});
            chk("sw_wdata", mem_wdata, d);
            step();
        end else begin
            chk("rmw_rd", mem_rd_en, 1);
            chk("rmw_wr1", mem_wr_en, 0);
            chk("rmw_addr1", mem_addr, {a[31:2], 2'b00});
            step();
            chk("rmw_idle2", {mem_rd_en, mem_wr_en, done}, 0);
            step();
            chk("rmw_wr", mem_wr_en, 1);
            chk("rmw_done", done, 1);
            chk("rmw_rd3", mem_rd_en, 0);
            chk("rmw_addr3", mem_addr, {a[31:2], 2'b00});
            chk("rmw_wdata", mem_wdata, w);
            step();
        end
        chk("ready_after", req_ready, 1);
        chk("quiet_after", {mem_rd_en, mem_wr_en, done, misalign_err}, 0);
    endtask

    initial begin
        int dones, d1, d2;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_outs", {mem_rd_en, mem_wr_en, done, misalign_err}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        step(); step();
        reset = 0;
        step();

        store(32'h10, 32'hDEADBEEF, 2'd2);
        chk("tp_sw", mem[4], 32'hDEADBEEF);
        store(32'h10, 32'h11223344, 2'd2);
        store(32'h13, 32'h123456AB, 2'd0);
        chk("tp_sb", mem[4], 32'hAB223344);
        store(32'h20, 32'hCAFEF00D, 2'd2);
        store(32'h22, 32'hFFFF8001, 2'd1);
        chk("tp_sh_hi", mem[8], 32'h8001F00D);
        store(32'h20, 32'hCAFEF00D, 2'd2);
        store(32'h20, 32'hFFFF8001, 2'd1);
        chk("tp_sh_lo", mem[8], 32'hCAFE8001);
        store(32'h05, 32'h0000BEEF, 2'd1);
        store(32'h06, 32'h01020304, 2'd2);
        store(32'h08, 32'h01020304, 2'd3);

        // reset during WAIT of a byte store: the write must never happen
        store(32'h30, 32'h55667788, 2'd2);
        req_valid = 1; req_addr = 32'h31; req_data = 32'hEE; req_size = 2'd0;
        step();
        req_valid = 0;
        chk("rst_mid_rd", mem_rd_en, 1);
        step();
        reset = 1;
        #1;
        chk("rst_mid_outs", {mem_rd_en, mem_wr_en, done, misalign_err}, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wdata", mem_wdata, 0);
        chk("rst_mid_ready", req_ready, 1);
        step(); step();
        reset = 0;
        step();
        chk("rst_mid_nowr", mem_wr_en, 0);
        step();
        chk("rst_mid_mem", mem[12], 32'h55667788);
        chk("rst_mid_ready2", req_ready, 1);

        // SB followed by a SW held on req_valid while busy
        ref_store(32'h03, 32'h99, 2'd0);
        ref_store(32'h08, 32'hA5A5A5A5, 2'd2);
        req_valid = 1; req_addr = 32'h03; req_data = 32'h99; req_size = 2'd0;
        step();
        req_addr = 32'h08; req_data = 32'hA5A5A5A5; req_size = 2'd2;
        dones = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 8; c++) begin
            chk("q_overlap", mem_rd_en & mem_wr_en, 0);
            if (done) begin
                dones++;
                if (dones == 1) d1 = c; else d2 = c;
                if (dones == 2) begin
                    req_valid = 0;
                    chk("q_sw_wdata", mem_wdata, 32'hA5A5A5A5);
                    chk("q_sw_addr", mem_addr, 32'h8);
                end
            end
            step();
        end
        req_valid = 0;
        chk("q_dones", dones, 2);
        chk("q_d1", d1, 3);
        chk("q_d2", d2, 5);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a, d;
            logic [1:0] s;
            a = {26'h0, 6'($urandom)};
            d = $urandom;
            s = 2'($urandom);
            store(a, d, s);
        end

        for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(w));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-path narrowing unit for the MIPS datapath: it performs SW/SH/SB by writing the low 32/16/8 bits of a register into a word-only data memory, the inverse of immediate/load widening. Word stores go straight to memory. Halfword and byte stores do a read-modify-write: read the word, merge the new lane, write it back. It sits between the execute stage's store request and the synchronous data memory, and flags misaligned accesses instead of issuing them.

## Interface
- ADDR_W, 32, byte-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit idle and able to accept
- req_addr  in  ADDR_W  byte address
- req_data  in  32  store source register (low bits used for SB/SH)
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_rd_en  out  1  read strobe; mem_rdata valid exactly 1 cycle later
- mem_rdata  in  32  memory read data
- mem_wr_en  out  1  write strobe
- mem_wdata  out  32  full word to write
- done  out  1  one-cycle pulse: store completed (coincides with mem_wr_en)
- misalign_err  out  1  one-cycle pulse: request rejected, no memory access

## Operation
- States: IDLE, READ, WAIT, WRITE.
- Accept when req_valid && req_ready. req_ready = 1 only in IDLE. On accept, latch addr, data and size. Inputs are ignored otherwise.
- Alignment check at accept:
  - halfword with addr[0]=1 → error
  - word with addr[1:0]≠0 → error
  - size 11 → error
- On error: misalign_err pulses the next cycle, state stays IDLE, and no mem strobe is issued.
- Word: IDLE → WRITE. mem_wdata = latched data.
- Byte/halfword: IDLE → READ (mem_rd_en=1) → WAIT (capture mem_rdata, merge) → WRITE → IDLE.
- Little-endian lanes:
  - byte k = addr[1:0] occupies bits [8k+7:8k] and is replaced by data[7:0]
  - halfword at addr[1]=h occupies bits [16h+15:16h] and is replaced by data[15:0]
  - all other bits keep their read values
- WRITE: mem_wr_en=1 and done=1 for exactly one cycle, then IDLE.
- mem_addr is held at the latched aligned address for the whole transaction; it is 0 in IDLE.
- No combinational path from req_* to any mem_* output. All mem_* and done/misalign_err are functions of registered state.

## Timing
- Reset values: state IDLE, req_ready=1, mem_rd_en=0, mem_wr_en=0, mem_wdata=0, mem_addr=0, done=0, misalign_err=0. All latched registers are 0.
- Accept at edge 0. Then:
  - word: write in cycle 1
  - byte/half: read in cycle 1, rdata sampled at end of cycle 2, write in cycle 3
- Latency: word 1 cycle, byte/half 3 cycles, error 1 cycle.
- Throughput: req_ready returns to 1 in the cycle after WRITE or after the error pulse. Back-to-back word stores therefore accept every 2 cycles.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at their reset values. No write occurs after reset, even if a read already completed.
- req_valid dropped after accept does not affect the transaction in progress.
- A new request held with req_valid during a busy transaction is accepted on the first cycle req_ready=1.

## Test plan
- SW addr 0x0000_0010, data 0xDEAD_BEEF → cycle 1: mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1; mem_rd_en never set.
- SB addr 0x0000_0013, data 0x1234_56AB, memory word 0x1122_3344 → read 0x10, then write 0xAB22_3344 with done at cycle 3.
- SH addr 0x0000_0022, data 0xFFFF_8001, memory word 0xCAFE_F00D → write 0x8001_F00D; SH at 0x20 → write 0xCAFE_8001.
- SH addr 0x0000_0005 and SW addr 0x0000_0006 and size 11 → misalign_err pulse 1 cycle after each accept; mem_rd_en=mem_wr_en=0 throughout.
- SB accepted, then reset asserted during WAIT → outputs go to reset values immediately, no mem_wr_en, req_ready=1 after reset release.
- req_valid held with SB then SW queued → second request accepted the cycle after the first done. Check exactly one done per accepted store and no overlapping strobes.
